// File: rtl/jtag_tap_responder.sv
// Target-side IEEE 1149.1 TAP with BYPASS, IDCODE and one USER data register.
// TCK/TMS/TDI/TRST_N are oversampled on clk; TCK edges become single-clk strobes.
module jtag_tap_responder #(
    parameter int              IR_W        = 4,
    parameter logic [31:0]     IDCODE_VAL  = 32'h0A5B_C001,
    parameter logic [IR_W-1:0] IR_IDCODE   = 'h1,
    parameter logic [IR_W-1:0] IR_USER     = 'h8,
    parameter int              USER_W      = 32,
    parameter int              SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tck,
    input  logic              tms,
    input  logic              tdi,
    input  logic              trst_n,
    output logic              tdo,
    output logic              tdo_en,
    output logic [3:0]        tap_state,
    input  logic [USER_W-1:0] user_capture_data,
    output logic              user_update_valid,
    output logic [USER_W-1:0] user_update_data
);

    typedef enum logic [3:0] {
        EXIT2_DR   = 4'h0,
        EXIT1_DR   = 4'h1,
        SHIFT_DR   = 4'h2,
        PAUSE_DR   = 4'h3,
        SELECT_IR  = 4'h4,
        UPDATE_DR  = 4'h5,
        CAPTURE_DR = 4'h6,
        SELECT_DR  = 4'h7,
        EXIT2_IR   = 4'h8,
        EXIT1_IR   = 4'h9,
        SHIFT_IR   = 4'hA,
        PAUSE_IR   = 4'hB,
        RUN_IDLE   = 4'hC,
        UPDATE_IR  = 4'hD,
        CAPTURE_IR = 4'hE,
        TLR        = 4'hF
    } tap_state_e;

    localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(2'b01);

    function automatic tap_state_e tap_next(input tap_state_e s, input logic m);
        case (s)
            TLR:        tap_next = m ? TLR       : RUN_IDLE;
            RUN_IDLE:   tap_next = m ? SELECT_DR : RUN_IDLE;
            SELECT_DR:  tap_next = m ? SELECT_IR : CAPTURE_DR;
            CAPTURE_DR: tap_next = m ? EXIT1_DR  : SHIFT_DR;
            SHIFT_DR:   tap_next = m ? EXIT1_DR  : SHIFT_DR;
            EXIT1_DR:   tap_next = m ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:   tap_next = m ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:   tap_next = m ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:  tap_next = m ? SELECT_DR : RUN_IDLE;
            SELECT_IR:  tap_next = m ? TLR       : CAPTURE_IR;
            CAPTURE_IR: tap_next = m ? EXIT1_IR  : SHIFT_IR;
            SHIFT_IR:   tap_next = m ? EXIT1_IR  : SHIFT_IR;
            EXIT1_IR:   tap_next = m ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:   tap_next = m ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:   tap_next = m ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:  tap_next = m ? SELECT_DR : RUN_IDLE;
            default:    tap_next = TLR;
        endcase
    endfunction

    // Input synchroniser: index 0 is the newest sample, bits are {trst_n, tdi, tms, tck}.
    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic                        tck_hist_q;
    logic                        tck_s, tms_s, tdi_s, trst_s;
    logic                        tck_rise, tck_fall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q     <= '0;
            tck_hist_q <= 1'b1;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], {trst_n, tdi, tms, tck}};
            tck_hist_q <= tck_s;
        end
    end

    assign tck_s    = sync_q[SYNC_STAGES-1][0];
    assign tms_s    = sync_q[SYNC_STAGES-1][1];
    assign tdi_s    = sync_q[SYNC_STAGES-1][2];
    assign trst_s   = sync_q[SYNC_STAGES-1][3];
    assign tck_rise = tck_s & ~tck_hist_q;
    assign tck_fall = ~tck_s & tck_hist_q;

    tap_state_e        state_q, state_d;
    logic [IR_W-1:0]   ir_q, ir_shift_q;
    logic [31:0]       idcode_shift_q;
    logic [USER_W-1:0] user_shift_q, user_data_q;
    logic              bypass_q;
    logic              tdo_q, tdo_en_q, user_valid_q;
    logic              sel_idcode, sel_user, shifting, shift_lsb;

    assign state_d    = tap_next(state_q, tms_s);
    assign sel_idcode = (ir_q == IR_IDCODE);
    assign sel_user   = (ir_q == IR_USER);
    assign shifting   = (state_q == SHIFT_IR) || (state_q == SHIFT_DR);

    always_comb begin
        shift_lsb = bypass_q;
        if (state_q == SHIFT_IR) begin
            shift_lsb = ir_shift_q[0];
        end else if (sel_idcode) begin
            shift_lsb = idcode_shift_q[0];
        end else if (sel_user) begin
            shift_lsb = user_shift_q[0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= TLR;
            ir_q           <= IR_IDCODE;
            ir_shift_q     <= '0;
            idcode_shift_q <= '0;
            user_shift_q   <= '0;
            bypass_q       <= 1'b0;
            tdo_q          <= 1'b0;
            tdo_en_q       <= 1'b0;
            user_valid_q   <= 1'b0;
            user_data_q    <= '0;
        end else begin
            user_valid_q <= 1'b0;
            if (!trst_s) begin
                state_q  <= TLR;
                ir_q     <= IR_IDCODE;
                tdo_en_q <= 1'b0;
            end else begin
                // Capture and shift act on the rise that leaves the current state.
                if (tck_rise) begin
                    state_q <= state_d;
                    case (state_q)
                        CAPTURE_IR: ir_shift_q <= IR_CAPTURE;
                        SHIFT_IR:   ir_shift_q <= {tdi_s, ir_shift_q[IR_W-1:1]};
                        CAPTURE_DR: begin
                            if (sel_idcode) begin
                                idcode_shift_q <= IDCODE_VAL;
                            end else if (sel_user) begin
                                user_shift_q <= user_capture_data;
                            end else begin
                                bypass_q <= 1'b0;
                            end
                        end
                        SHIFT_DR: begin
                            if (sel_idcode) begin
                                idcode_shift_q <= {tdi_s, idcode_shift_q[31:1]};
                            end else if (sel_user) begin
                                user_shift_q <= {tdi_s, user_shift_q[USER_W-1:1]};
                            end else begin
                                bypass_q <= tdi_s;
                            end
                        end
                        default: ;
                    endcase
                end
                if (tck_fall) begin
                    tdo_en_q <= shifting;
                    if (shifting) begin
                        tdo_q <= shift_lsb;
                    end
                    if (state_q == UPDATE_IR) begin
                        ir_q <= ir_shift_q;
                    end
                    if (state_q == UPDATE_DR && sel_user) begin
                        user_data_q  <= user_shift_q;
                        user_valid_q <= 1'b1;
                    end
                end
                if (state_q == TLR) begin
                    ir_q <= IR_IDCODE;
                end
            end
        end
    end

    assign tdo               = tdo_q;
    assign tdo_en            = tdo_en_q;
    assign tap_state         = state_q;
    assign user_update_valid = user_valid_q;
    assign user_update_data  = user_data_q;

endmodule
